cbd_coeff_streamer: RTL and testbench
=====================================

Name: cbd_coeff_streamer

Overview:
- Sits directly downstream of the CBD noise sampler.
- Captures one sampled noise polynomial: 256 signed 16-bit coefficients in [-eta, eta], packed into 4096 bits, coefficient i at bits [16i+15:16i].
- Maps each coefficient into the canonical range [0, q-1].
- Streams the coefficients, one per cycle, over a valid/ready handshake into the polynomial RAM / NTT input stage that builds r, e1 and e2.

Parameters:
- N, 256, coefficients per polynomial.
- COEFF_W, 16, width of each packed input coefficient (two's complement).
- Q, 3329, Kyber modulus.
- OUT_W, 12, output coefficient width; must satisfy 2^OUT_W > Q.
- ETA, 2, maximum legal |coefficient|.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to capture poly_in.
- poly_in, input, N*COEFF_W, packed signed coefficients from the sampler.
- busy, output, 1, high from capture until the final handshake completes.
- out_valid, output, 1, out_data/out_idx/out_last are valid.
- out_ready, input, 1, consumer accepts the current word.
- out_data, output, OUT_W, coefficient mod Q in [0, Q-1].
- out_idx, output, 8, index of the current coefficient (0..N-1).
- out_last, output, 1, high with out_valid when out_idx == N-1.
- done, output, 1, one-cycle pulse after the last coefficient is accepted.
- range_err, output, 1, sticky; set if any captured coefficient lies outside [-ETA, ETA]. Cleared on the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy, out_valid, out_last, done, range_err = 0; out_data = 0; out_idx = 0.
  - The capture buffer is cleared.
  - Reset asserted mid-stream aborts the stream; no done pulse is produced.
- States: IDLE, STREAM, FINISH.
- IDLE:
  - start=1 latches poly_in into an internal N*COEFF_W buffer on that edge, clears range_err and the index counter, and moves to STREAM.
  - busy rises on the same edge.
- STREAM:
  - out_valid=1 from the first cycle after capture (latency start -> first valid = 1 cycle).
  - out_data = buf[idx] when buf[idx] >= 0, else buf[idx] + Q, truncated to OUT_W.
  - Example mappings: -2 -> 3327, -1 -> 3328, 0 -> 0, 2 -> 2.
  - A handshake (out_valid & out_ready) advances idx by 1.
  - While out_ready=0, out_data/out_idx/out_last hold stable; the AXI-style rule applies: valid never drops without a handshake.
  - range_err is evaluated on the word presented at each handshake; once set it stays set.
  - Out-of-range values are still streamed, using the same mapping applied to the raw signed value, reduced mod Q.
  - A handshake at idx == N-1 moves to FINISH and drops out_valid on the same edge. idx does not wrap.
- FINISH:
  - done=1 for exactly one cycle; busy=0 in this cycle; return to IDLE.
- start in STREAM or FINISH is ignored; the buffer is not overwritten.
- start in the same cycle the IDLE -> capture would occur is the only accepted case. No queuing.
- Sustained throughput: one coefficient per cycle when out_ready is held high.
- Total time: start edge to done pulse = N+1 cycles minimum.
- The combinational path poly_in -> buffer uses a registered capture only. out_data is produced from the buffer plus a mux by idx plus one conditional add; output registers are allowed if latency remains 1 start -> valid.

Decomposition:
- Shared package (kyber_pkg):
  - KYBER_N=256, KYBER_Q=3329, KYBER_ETA=2, COEFF_W=16, OUT_W=12.
  - typedef coeff_t (logic signed [15:0]).
  - typedef zq_t (logic [11:0]).
- One sub-module: coeff_to_zq. Purely combinational: signed COEFF_W in, zq_t out, plus an out_of_range flag. Reused later for e2/message addition.

Test Plan:
- All-zero poly, out_ready held 1 -> 256 words of 0; idx 0..255; out_last only on idx 255; done pulse exactly 257 cycles after start edge; busy low afterward.
- poly with coeff[i] = (i mod 5) - 2 -> words cycle 3327, 3328, 0, 1, 2; range_err stays 0.
- Random out_ready backpressure (about 50%) -> data/idx stable while stalled; exactly 256 handshakes; sequence identical to the unstalled run.
- coeff[17] = -3, coeff[200] = 5 -> range_err set at the idx-17 handshake and remains 1 through done; word 17 = 3326, word 200 = 5; next start clears range_err.
- start pulsed at idx 100 with a different poly_in -> ignored; stream continues from the original buffer; a new start after done is accepted.
- rst_n low at idx 50 -> all outputs 0 immediately (asynchronous); no done pulse; a following start streams from idx 0.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and coefficient types used by the sampler-side datapath.
// Both the noise streamer and the later e2/message adders import this package.
package kyber_pkg;

    localparam int KYBER_N   = 256;
    localparam int KYBER_Q   = 3329;
    localparam int KYBER_ETA = 2;
    localparam int COEFF_W   = 16;
    localparam int OUT_W     = 12;

    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef logic        [OUT_W-1:0]   zq_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FINISH
    } state_t;

endpackage

// File: rtl/coeff_to_zq.sv
// Maps a small signed coefficient into [0, Q-1] with a single conditional add of Q.
// The add result is truncated to OUT_W, so only inputs in roughly [-Q, Q) land canonically.
module coeff_to_zq
    import kyber_pkg::*;
#(
    parameter int Q   = KYBER_Q,
    parameter int ETA = KYBER_ETA
) (
    input  coeff_t coeff,
    output zq_t    zq,
    output logic   out_of_range
);

    localparam coeff_t Q_S   = coeff_t'(Q);
    localparam coeff_t ETA_S = coeff_t'(ETA);

    always_comb begin
        zq           = coeff[COEFF_W-1] ? zq_t'(coeff + Q_S) : zq_t'(coeff);
        out_of_range = (coeff > ETA_S) || (coeff < -ETA_S);
    end

endmodule

// File: rtl/cbd_coeff_streamer.sv
// Captures one CBD noise polynomial and streams its coefficients, reduced into Z_q,
// one per cycle over a valid/ready handshake to the polynomial RAM / NTT input stage.
module cbd_coeff_streamer #(
    parameter int N       = kyber_pkg::KYBER_N,
    parameter int COEFF_W = kyber_pkg::COEFF_W,
    parameter int Q       = kyber_pkg::KYBER_Q,
    parameter int OUT_W   = kyber_pkg::OUT_W,
    parameter int ETA     = kyber_pkg::KYBER_ETA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N*COEFF_W-1:0] poly_in,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [7:0]           out_idx,
    output logic                 out_last,
    output logic                 done,
    output logic                 range_err
);

    import kyber_pkg::*;

    localparam logic [7:0] IDX_LAST = 8'(N - 1);

    state_t     state;
    coeff_t     poly_arr   [N];
    coeff_t     cap_buf_p0 [N];
    logic [7:0] idx_p0;
    coeff_t     cur_coeff;
    zq_t        cur_zq;
    logic       cur_oor;
    logic       hs;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign poly_arr[g] = poly_in[g*COEFF_W +: COEFF_W];
    end

    // Stage p0: captured buffer and read index; everything below is combinational off them.
    assign cur_coeff = cap_buf_p0[idx_p0];
    assign hs        = out_valid && out_ready;

    coeff_to_zq #(
        .Q   (Q),
        .ETA (ETA)
    ) u_coeff_to_zq (
        .coeff        (cur_coeff),
        .zq           (cur_zq),
        .out_of_range (cur_oor)
    );

    assign out_data = cur_zq;
    assign out_idx  = idx_p0;
    assign out_last = out_valid && (idx_p0 == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            range_err  <= 1'b0;
            idx_p0     <= '0;
            cap_buf_p0 <= '{default: '0};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_buf_p0 <= poly_arr;
                        range_err  <= 1'b0;
                        idx_p0     <= '0;
                        busy       <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (cur_oor) begin
                            range_err <= 1'b1;
                        end
                        // The index parks on the last entry rather than wrapping.
                        if (idx_p0 == IDX_LAST) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            idx_p0 <= idx_p0 + 8'd1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbd_coeff_streamer.sv
// Directed bench for cbd_coeff_streamer: full streams, backpressure, range errors,
// ignored starts and asynchronous abort, all checked against hand-derived Z_q values.
module tb_cbd_coeff_streamer;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [4095:0] poly_in = '0;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          out_valid;
    logic [11:0]   out_data;
    logic [7:0]    out_idx;
    logic          out_last;
    logic          done;
    logic          range_err;

    int total = 0;
    int bad = 0;

    int zero_c [256];
    int pat_c  [256];
    int err_c  [256];
    int one_c  [256];

    int got_data    [256];
    int got_idx     [256];
    int got_last    [256];
    int rerr_before [256];
    int ref_data    [256];

    int   nhs;
    int   done_cyc;
    logic rerr_at_done;
    logic busy_at_done;
    int   aborted;

    cbd_coeff_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .poly_in   (poly_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_of(input int c);
        return (c < 0) ? c + 3329 : c;
    endfunction

    function automatic logic [4095:0] pack(input int c [256]);
        logic [4095:0] p;
        p = '0;
        for (int i = 0; i < 256; i++) begin
            p = {16'(c[i]), p[4095:16]};
        end
        return p;
    endfunction

    task automatic do_start(input logic [4095:0] p);
        @(negedge clk);
        poly_in = p;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_stream(input int rnd, input int inject_at, input logic [4095:0] alt_p,
                              input int abort_at);
        int         cyc;
        logic       prev_stall;
        logic [11:0] pd;
        logic [7:0] pi;
        logic       r;
        nhs = 0;
        done_cyc = -1;
        aborted = 0;
        prev_stall = 1'b0;
        cyc = 0;
        pd = '0;
        pi = '0;
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (prev_stall) begin
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_data", 32'(out_data), 32'(pd));
                check_eq("stall_idx", 32'(out_idx), 32'(pi));
            end
            if (done) begin
                done_cyc     = cyc;
                rerr_at_done = range_err;
                busy_at_done = busy;
                break;
            end
            if (abort_at >= 0 && out_valid && out_idx == 8'(abort_at)) begin
                rst_n   = 1'b0;
                aborted = 1;
                break;
            end
            if (inject_at >= 0 && out_valid && out_idx == 8'(inject_at)) begin
                start   = 1'b1;
                poly_in = alt_p;
            end
            r = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (out_valid && r) begin
                if (nhs < 256) begin
                    got_data[nhs]    = int'(out_data);
                    got_idx[nhs]     = int'(out_idx);
                    got_last[nhs]    = int'(out_last);
                    rerr_before[nhs] = int'(range_err);
                end
                nhs++;
            end
            prev_stall = out_valid && !r;
            pd = out_data;
            pi = out_idx;
        end
        start = 1'b0;
        if (aborted == 0 && done_cyc < 0) begin
            check_eq("timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic check_words(input string tag, input int c [256]);
        for (int i = 0; i < 256; i++) begin
            check_eq($sformatf("%s.data[%0d]", tag, i), 32'(got_data[i]), 32'(exp_of(c[i])));
            check_eq($sformatf("%s.idx[%0d]", tag, i), 32'(got_idx[i]), 32'(i));
            check_eq($sformatf("%s.last[%0d]", tag, i), 32'(got_last[i]), (i == 255) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".last"}, 32'(out_last), 32'd0);
        check_eq({tag, ".done"}, 32'(done), 32'd0);
        check_eq({tag, ".range_err"}, 32'(range_err), 32'd0);
        check_eq({tag, ".data"}, 32'(out_data), 32'd0);
        check_eq({tag, ".idx"}, 32'(out_idx), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            zero_c[i] = 0;
            pat_c[i]  = (i % 5) - 2;
            err_c[i]  = 0;
            one_c[i]  = 1;
        end
        err_c[17]  = -3;
        err_c[200] = 5;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero polynomial, no backpressure
        do_start(pack(zero_c));
        check_eq("zero.busy_after_start", 32'(busy), 32'd1);
        run_stream(0, -1, '0, -1);
        check_eq("zero.handshakes", 32'(nhs), 32'd256);
        check_eq("zero.done_cycle", 32'(done_cyc), 32'd257);
        check_eq("zero.busy_at_done", 32'(busy_at_done), 32'd0);
        check_words("zero", zero_c);
        @(negedge clk);
        check_eq("zero.done_one_cycle", 32'(done), 32'd0);
        check_eq("zero.busy_after", 32'(busy), 32'd0);
        check_eq("zero.valid_after", 32'(out_valid), 32'd0);

        // Cycling -2..2 pattern, no backpressure
        do_start(pack(pat_c));
        run_stream(0, -1, '0, -1);
        check_eq("pat.handshakes", 32'(nhs), 32'd256);
        check_eq("pat.done_cycle", 32'(done_cyc), 32'd257);
        check_eq("pat.w0", 32'(got_data[0]), 32'd3327);
        check_eq("pat.w1", 32'(got_data[1]), 32'd3328);
        check_eq("pat.w2", 32'(got_data[2]), 32'd0);
        check_eq("pat.w3", 32'(got_data[3]), 32'd1);
        check_eq("pat.w4", 32'(got_data[4]), 32'd2);
        check_eq("pat.w255", 32'(got_data[255]), 32'd3327);
        check_eq("pat.range_err", 32'(rerr_at_done), 32'd0);
        check_words("pat", pat_c);
        for (int i = 0; i < 256; i++) ref_data[i] = got_data[i];

        // Same pattern under random backpressure
        do_start(pack(pat_c));
        run_stream(1, -1, '0, -1);
        check_eq("bp.handshakes", 32'(nhs), 32'd256);
        check_eq("bp.done_seen", 32'(done_cyc > 257), 32'd1);
        for (int i = 0; i < 256; i++) begin
            check_eq($sformatf("bp.same[%0d]", i), 32'(got_data[i]), 32'(ref_data[i]));
        end
        check_words("bp", pat_c);

        // Out-of-range coefficients at 17 and 200
        do_start(pack(err_c));
        run_stream(0, -1, '0, -1);
        check_eq("err.handshakes", 32'(nhs), 32'd256);
        check_eq("err.w17", 32'(got_data[17]), 32'd3326);
        check_eq("err.w200", 32'(got_data[200]), 32'd5);
        check_eq("err.rerr_before17", 32'(rerr_before[17]), 32'd0);
        check_eq("err.rerr_after17", 32'(rerr_before[18]), 32'd1);
        check_eq("err.rerr_at_done", 32'(rerr_at_done), 32'd1);
        check_words("err", err_c);

        // Next start clears range_err; a start mid-stream is ignored
        do_start(pack(pat_c));
        check_eq("restart.range_err_clear", 32'(range_err), 32'd0);
        run_stream(0, 100, pack(one_c), -1);
        check_eq("inject.handshakes", 32'(nhs), 32'd256);
        check_eq("inject.done_cycle", 32'(done_cyc), 32'd257);
        check_words("inject", pat_c);

        // A start after done is accepted
        do_start(pack(one_c));
        run_stream(0, -1, '0, -1);
        check_eq("after.handshakes", 32'(nhs), 32'd256);
        check_words("after", one_c);

        // Asynchronous reset at idx 50
        do_start(pack(pat_c));
        run_stream(0, -1, '0, 50);
        check_eq("abort.taken", 32'(aborted), 32'd1);
        #1;
        check_idle_zero("abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("abort.no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        do_start(pack(pat_c));
        check_eq("abort.restart_idx", 32'(out_idx), 32'd0);
        run_stream(0, -1, '0, -1);
        check_eq("abort.handshakes", 32'(nhs), 32'd256);
        check_words("abort", pat_c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
